mem_stage_ctrl: RTL

//  MEM pipeline stage directly downstream of the EX stage. Registers EX results (ALU result,

---
 rtl/mem_stage_ctrl_pkg.sv | 39 +++
 rtl/mem_stage_ctrl_if.sv | 24 ++
 rtl/mem_stage_ctrl_timer.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and default widths for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned MS_DATA_W   = 32;
  localparam int unsigned MS_ADDR_W   = 32;
  localparam int unsigned MS_RD_W     = 4;
  localparam int unsigned MS_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  // EX/MEM pipeline register
  typedef struct packed {
    logic                 valid;
    logic [MS_DATA_W-1:0] alu_result;
    logic [MS_DATA_W-1:0] write_data;
    logic [MS_RD_W-1:0]   rd;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
  } ex_mem_t;

  // MEM/WB pipeline register
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [MS_RD_W-1:0]   rd;
    logic [MS_DATA_W-1:0] data;
  } mem_wb_t;

  // A real instruction that touches data memory.
  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack port of the MEM stage.
interface mem_stage_ctrl_if
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = MS_DATA_W,
  parameter int unsigned ADDR_W = MS_ADDR_W
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_timer.sv
// Saturating wait counter with clear/enable; 'last' flags the final allowed cycle.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // Count un-acked BUSY cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != CW'(MAX_WAIT)) begin
      count <= count + 1'b1;
    end
  end

  // One more un-acked cycle makes the count reach MAX_WAIT.
  assign last = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, data-memory req/ack
// sequencing with upstream stall, and a fatal timeout state.
// The pipeline structs use the package widths; the width parameters must match them.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = MS_DATA_W,
  parameter int unsigned ADDR_W   = MS_ADDR_W,
  parameter int unsigned RD_W     = MS_RD_W,
  parameter int unsigned MAX_WAIT = MS_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  output logic              stall,
  mem_stage_ctrl_if.master  dmem,
  output logic [DATA_W-1:0] fw_mem_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  mem_state_t state, state_nx;
  ex_mem_t    m;
  mem_wb_t    w, w_nx;
  logic       timer_clr, timer_en, timer_last;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .en   (timer_en),
    .last (timer_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, stall and memory-port drive.
  always_comb begin
    state_nx         = state;
    stall            = 1'b0;
    timer_clr        = 1'b0;
    timer_en         = 1'b0;
    dmem.dmem_req    = 1'b0;
    dmem.dmem_we     = 1'b0;
    dmem.dmem_addr   = '0;
    dmem.dmem_wdata  = '0;
    unique case (state)
      IDLE: ;
      BUSY: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = m.mem_write;
        dmem.dmem_addr  = m.alu_result[ADDR_W-1:0];
        dmem.dmem_wdata = m.write_data;
        if (!dmem.dmem_ack) begin
          stall    = 1'b1;
          timer_en = 1'b1;
          if (timer_last) state_nx = ERR;
        end
      end
      ERR:     stall = 1'b1;
      default: begin
        stall    = 1'b1;
        state_nx = ERR;
      end
    endcase
    if (!stall) begin
      state_nx  = is_mem_op(ex_valid, ex_mem_read, ex_mem_write) ? BUSY : IDLE;
      timer_clr = is_mem_op(ex_valid, ex_mem_read, ex_mem_write);
    end
  end

  // Content handed to MEM/WB on an advance; read+write counts as a store.
  always_comb begin
    w_nx           = '0;
    w_nx.valid     = m.valid;
    w_nx.reg_write = m.valid & m.reg_write & ~m.mem_write;
    w_nx.rd        = m.rd;
    w_nx.data      = (state == BUSY && m.mem_read && !m.mem_write) ? dmem.dmem_rdata
                                                                  : m.alu_result;
  end

  // EX/MEM and MEM/WB registers advance together when not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      w <= '0;
    end else if (!stall) begin
      m.valid      <= ex_valid;
      m.alu_result <= ex_alu_result;
      m.write_data <= ex_write_data;
      m.rd         <= ex_rd;
      m.mem_read   <= ex_mem_read;
      m.mem_write  <= ex_mem_write;
      m.reg_write  <= ex_reg_write;
      w            <= w_nx;
    end else if (state_nx == ERR) begin
      // A frozen MEM/WB must not keep presenting a valid write once failed.
      w.valid     <= 1'b0;
      w.reg_write <= 1'b0;
    end
  end

  assign fw_mem_data  = m.alu_result;
  assign wb_valid     = w.valid;
  assign wb_reg_write = w.reg_write;
  assign wb_rd        = w.rd;
  assign wb_data      = w.data;
  assign mem_err      = (state == ERR);

endmodule
